// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel synchroniser, debounce, edge and event detect.
// Define MULTI_EDGE_DETECTOR_EDGE_COUNT_EN to add saturating per-channel event counters.
module multi_edge_detector #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     clear,
  output logic [N-1:0]     level,
  output logic [N-1:0]     positive_edge,
  output logic [N-1:0]     negative_edge,
  output logic [N-1:0]     event_pulse,
  output logic [N-1:0]     event_flag
`ifdef MULTI_EDGE_DETECTOR_EDGE_COUNT_EN
  ,
  output logic [N*CNT_W-1:0] edge_count
`endif
);

  localparam int DW =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] w_sync;
  logic [N-1:0] w_level_nx;
  logic [N-1:0] r_level;
  logic [N-1:0] r_prev;
  logic [N-1:0] r_pos;
  logic [N-1:0] r_neg;
  logic [N-1:0] r_flag;
  logic [N-1:0] w_event;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    if (DEBOUNCE_CYCLES < 2) begin : g_nofilt
      assign w_level_nx[i] = w_sync[i];
    end else begin : g_filt
      localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
      logic [DW-1:0] r_dcnt;
      logic          w_diff;
      logic          w_accept;

      assign w_diff   = w_sync[i] != r_level[i];
      assign w_accept = w_diff && (r_dcnt == D_LAST);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dcnt <= '0;
        end else if (!w_diff || w_accept) begin
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end

      assign w_level_nx[i] = w_accept ? w_sync[i] : r_level[i];
    end

    assign w_event[i] = (mode[2*i]   & r_pos[i])
                      | (mode[2*i+1] & r_neg[i]);
  end

  // Pulses are taken from the accepted level and its one-cycle-old copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
      r_prev  <= '0;
      r_pos   <= '0;
      r_neg   <= '0;
      r_flag  <= '0;
    end else begin
      r_level <= w_level_nx;
      r_prev  <= r_level;
      r_pos   <= r_level & ~r_prev;
      r_neg   <= ~r_level & r_prev;
      r_flag  <= w_event | (r_flag & ~clear);
    end
  end

`ifdef MULTI_EDGE_DETECTOR_EDGE_COUNT_EN
  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (clear[i]) begin
        r_cnt <= CNT_W'(w_event[i]);
      end else if (w_event[i] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign edge_count[i*CNT_W +: CNT_W] = r_cnt;
  end
`endif

  assign level         = r_level;
  assign positive_edge = r_pos;
  assign negative_edge = r_neg;
  assign event_pulse   = w_event;
  assign event_flag    = r_flag;

endmodule
